// File: rtl/ni_tdm_lut_conf_loader.sv
// Expands valid/ready configuration commands into one-per-cycle slot-table and
// link-enable write strobes for the NI TDM channel block.
module ni_tdm_lut_conf_loader #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CT_LINKS = 2,
    parameter int unsigned LUT_SIZE = 8,
    localparam int unsigned NTAB    = 2 * CT_LINKS,
    localparam int unsigned SEL_W   = ($clog2(NTAB) > $clog2(CHANNELS)) ? $clog2(NTAB) : $clog2(CHANNELS),
    localparam int unsigned SLOT_W  = $clog2(LUT_SIZE),
    localparam int unsigned DATA_W  = $clog2(CHANNELS + 1)
) (
    input  logic              clk_noc,
    input  logic              rst_noc,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_op,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [SLOT_W-1:0] cfg_slot_end,
    input  logic [DATA_W-1:0] cfg_data,
    output logic [DATA_W-1:0] lut_conf_data,
    output logic [SEL_W-1:0]  lut_conf_sel,
    output logic [SLOT_W-1:0] lut_conf_slot,
    output logic              lut_conf_valid,
    output logic              link_en_valid,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_FILL  = 2'd1;
    localparam logic [1:0] OP_LINK  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_FILL, S_LINK, S_CLR_LUT, S_CLR_LINK, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic [SLOT_W-1:0] slot_q, slot_nxt;
    logic [SLOT_W-1:0] end_q, end_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [SLOT_W-1:0] slot_wrap;
    logic              cmd_bad;

    logic              lut_valid_d, link_valid_d, strobe_d;
    logic [SEL_W-1:0]  sel_d;
    logic [SLOT_W-1:0] slot_d;
    logic [DATA_W-1:0] data_d;

    // Command validation against the configured table/channel/link counts
    always_comb begin
        cmd_bad = 1'b0;
        case (cfg_op)
            OP_WRITE, OP_FILL: begin
                cmd_bad = (32'(cfg_sel) >= NTAB) || (32'(cfg_data) > CHANNELS) ||
                          (32'(cfg_slot) >= LUT_SIZE) ||
                          ((cfg_op == OP_FILL) && (32'(cfg_slot_end) >= LUT_SIZE));
            end
            OP_LINK: begin
                cmd_bad = (32'(cfg_sel) >= CHANNELS) || (32'(cfg_slot) >= CT_LINKS);
            end
            default: cmd_bad = 1'b0;
        endcase
    end

    assign slot_wrap = (slot_q == SLOT_W'(LUT_SIZE - 1)) ? '0 : slot_q + SLOT_W'(1);

    // State register with command capture and registered outputs
    always_ff @(posedge clk_noc) begin
        if (!rst_noc) begin
            state          <= S_IDLE;
            sel_q          <= '0;
            slot_q         <= '0;
            end_q          <= '0;
            data_q         <= '0;
            cfg_ready      <= 1'b1;
            lut_conf_valid <= 1'b0;
            link_en_valid  <= 1'b0;
            lut_conf_sel   <= '0;
            lut_conf_slot  <= '0;
            lut_conf_data  <= '0;
            busy           <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            state          <= state_nxt;
            sel_q          <= sel_nxt;
            slot_q         <= slot_nxt;
            end_q          <= end_nxt;
            data_q         <= data_nxt;
            cfg_ready      <= (state_nxt == S_IDLE);
            lut_conf_valid <= lut_valid_d;
            link_en_valid  <= link_valid_d;
            lut_conf_sel   <= sel_d;
            lut_conf_slot  <= slot_d;
            lut_conf_data  <= data_d;
            busy           <= (state_nxt != S_IDLE);
            cfg_done       <= (state_nxt == S_DONE);
            cfg_err        <= (state_nxt == S_ERR);
        end
    end

    // Next-state and walk-pointer update
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        slot_nxt  = slot_q;
        end_nxt   = end_q;
        data_nxt  = data_q;
        case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    sel_nxt  = cfg_sel;
                    slot_nxt = cfg_slot;
                    end_nxt  = cfg_slot_end;
                    data_nxt = cfg_data;
                    if (cmd_bad) begin
                        state_nxt = S_ERR;
                    end else begin
                        case (cfg_op)
                            OP_WRITE: state_nxt = S_WRITE;
                            OP_FILL:  state_nxt = S_FILL;
                            OP_LINK: begin
                                state_nxt = S_LINK;
                                data_nxt  = DATA_W'(cfg_data[0]);
                            end
                            default: begin
                                state_nxt = S_CLR_LUT;
                                sel_nxt   = '0;
                                slot_nxt  = '0;
                                data_nxt  = DATA_W'(CHANNELS);
                            end
                        endcase
                    end
                end
            end
            S_WRITE, S_LINK: state_nxt = S_DONE;
            S_FILL: begin
                if (slot_q == end_q) state_nxt = S_DONE;
                else                 slot_nxt  = slot_wrap;
            end
            S_CLR_LUT: begin
                if (slot_q == SLOT_W'(LUT_SIZE - 1)) begin
                    slot_nxt = '0;
                    if (sel_q == SEL_W'(NTAB - 1)) begin
                        sel_nxt   = '0;
                        data_nxt  = '0;
                        state_nxt = S_CLR_LINK;
                    end else begin
                        sel_nxt = sel_q + SEL_W'(1);
                    end
                end else begin
                    slot_nxt = slot_q + SLOT_W'(1);
                end
            end
            S_CLR_LINK: begin
                if (slot_q == SLOT_W'(CT_LINKS - 1)) begin
                    slot_nxt = '0;
                    if (sel_q == SEL_W'(CHANNELS - 1)) state_nxt = S_DONE;
                    else                               sel_nxt   = sel_q + SEL_W'(1);
                end else begin
                    slot_nxt = slot_q + SLOT_W'(1);
                end
            end
            S_DONE, S_ERR: state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state; strobe fields are zero when idle
    always_comb begin
        lut_valid_d  = (state_nxt == S_WRITE) || (state_nxt == S_FILL) || (state_nxt == S_CLR_LUT);
        link_valid_d = (state_nxt == S_LINK) || (state_nxt == S_CLR_LINK);
        strobe_d     = lut_valid_d || link_valid_d;
        sel_d        = strobe_d ? sel_nxt  : '0;
        slot_d       = strobe_d ? slot_nxt : '0;
        data_d       = strobe_d ? data_nxt : '0;
    end

endmodule

// File: tb/tb_ni_tdm_lut_conf_loader.sv
// Scoreboard bench for ni_tdm_lut_conf_loader: driver queues expected strobe/done/err
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_ni_tdm_lut_conf_loader;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned CT_LINKS = 2;
    localparam int unsigned LUT_SIZE = 8;
    localparam int unsigned NTAB     = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned SLOT_W   = 3;
    localparam int unsigned DATA_W   = 3;

    localparam int K_LUT  = 0;
    localparam int K_LINK = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic              clk_noc;
    logic              rst_noc;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_op;
    logic [SEL_W-1:0]  cfg_sel;
    logic [SLOT_W-1:0] cfg_slot;
    logic [SLOT_W-1:0] cfg_slot_end;
    logic [DATA_W-1:0] cfg_data;
    logic [DATA_W-1:0] lut_conf_data;
    logic [SEL_W-1:0]  lut_conf_sel;
    logic [SLOT_W-1:0] lut_conf_slot;
    logic              lut_conf_valid;
    logic              link_en_valid;
    logic              busy;
    logic              cfg_done;
    logic              cfg_err;

    ni_tdm_lut_conf_loader #(
        .CHANNELS(CHANNELS), .CT_LINKS(CT_LINKS), .LUT_SIZE(LUT_SIZE)
    ) dut (
        .clk_noc(clk_noc), .rst_noc(rst_noc),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_sel(cfg_sel), .cfg_slot(cfg_slot), .cfg_slot_end(cfg_slot_end),
        .cfg_data(cfg_data),
        .lut_conf_data(lut_conf_data), .lut_conf_sel(lut_conf_sel),
        .lut_conf_slot(lut_conf_slot), .lut_conf_valid(lut_conf_valid),
        .link_en_valid(link_en_valid), .busy(busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    typedef struct {
        int kind;
        int sel;
        int slot;
        int data;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    initial clk_noc = 1'b0;
    always #5 clk_noc = ~clk_noc;
    always @(posedge clk_noc) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mk(inout ev_t q[$], input int k, input int s, input int sl, input int d, input int c);
        ev_t e;
        e.kind = k; e.sel = s; e.slot = sl; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Drive one command; lim>=0 keeps only the first lim strobes and no done
    task automatic issue(input int op, input int sel, input int slot, input int send,
                         input int data, input bit bad, input int lim, output int acc);
        ev_t tmp[$];
        int  n;
        int  cnt;
        cfg_op       = 2'(op);
        cfg_sel      = SEL_W'(sel);
        cfg_slot     = SLOT_W'(slot);
        cfg_slot_end = SLOT_W'(send);
        cfg_data     = DATA_W'(data);
        cfg_valid    = 1'b1;
        n = 0;
        while (!cfg_ready && n < 300) begin
            @(negedge clk_noc);
            n++;
        end
        if (!cfg_ready) begin
            chk("accept_timeout", 0, 1);
            cfg_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (bad) begin
            mk(tmp, K_ERR, 0, 0, 0, acc);
        end else begin
            case (op)
                0: mk(tmp, K_LUT, sel, slot, data, acc);
                1: begin
                    cnt = ((send - slot) % int'(LUT_SIZE) + int'(LUT_SIZE)) % int'(LUT_SIZE) + 1;
                    for (int i = 0; i < cnt; i++)
                        mk(tmp, K_LUT, sel, (slot + i) % int'(LUT_SIZE), data, acc + i);
                end
                2: mk(tmp, K_LINK, sel, slot, data & 1, acc);
                default: begin
                    for (int t = 0; t < int'(NTAB); t++)
                        for (int s = 0; s < int'(LUT_SIZE); s++)
                            mk(tmp, K_LUT, t, s, int'(CHANNELS), acc + tmp.size());
                    for (int ch = 0; ch < int'(CHANNELS); ch++)
                        for (int l = 0; l < int'(CT_LINKS); l++)
                            mk(tmp, K_LINK, ch, l, 0, acc + tmp.size());
                end
            endcase
            if (lim < 0) mk(tmp, K_DONE, 0, 0, 0, acc + tmp.size());
        end
        for (int i = 0; i < tmp.size(); i++)
            if (lim < 0 || i < lim) exp_q.push_back(tmp[i]);
        @(posedge clk_noc);
        @(negedge clk_noc);
        cfg_valid    = 1'b0;
        cfg_op       = ~cfg_op;
        cfg_sel      = ~cfg_sel;
        cfg_slot     = ~cfg_slot;
        cfg_slot_end = ~cfg_slot_end;
        cfg_data     = ~cfg_data;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        chk({tag, "_lut_conf_valid"}, int'(lut_conf_valid), 0);
        chk({tag, "_link_en_valid"}, int'(link_en_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cfg_done"}, int'(cfg_done), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_lut_fields"}, int'({lut_conf_sel, lut_conf_slot, lut_conf_data}), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_noc);
            n++;
        end
        repeat (3) @(negedge clk_noc);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: compare every presented event against the head of the queue
    always @(negedge clk_noc) begin
        ev_t e;
        int  k;
        if (lut_conf_valid || link_en_valid || cfg_done || cfg_err) begin
            k = lut_conf_valid ? K_LUT : link_en_valid ? K_LINK : cfg_done ? K_DONE : K_ERR;
            if (exp_q.size() == 0) begin
                chk("unexpected_event_kind", k, -1);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind", k, e.kind);
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_sel", int'(lut_conf_sel), e.sel);
                chk("ev_slot", int'(lut_conf_slot), e.slot);
                chk("ev_data", int'(lut_conf_data), e.data);
            end
        end
        if (lut_conf_valid && link_en_valid) chk("strobe_exclusive", 1, 0);
        if (lut_conf_valid || link_en_valid) begin
            chk("strobe_busy", int'(busy), 1);
            chk("strobe_ready_low", int'(cfg_ready), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a2;
        rst_noc      = 1'b0;
        cfg_valid    = 1'b0;
        cfg_op       = '0;
        cfg_sel      = '0;
        cfg_slot     = '0;
        cfg_slot_end = '0;
        cfg_data     = '0;
        repeat (3) @(posedge clk_noc);
        @(negedge clk_noc);
        chk_idle("reset");
        rst_noc = 1'b1;
        @(negedge clk_noc);

        issue(0, 1, 5, 0, 2, 1'b0, -1, a);   // WRITE 1/5/2
        issue(1, 2, 6, 1, 3, 1'b0, -1, a);   // FILL wrap 6,7,0,1
        issue(1, 3, 4, 4, 4, 1'b0, -1, a);   // FILL single slot, idle channel
        issue(1, 0, 0, 7, 1, 1'b0, -1, a);   // FILL whole table
        issue(2, 3, 1, 0, 1, 1'b0, -1, a);   // LINK_EN enable
        issue(2, 0, 0, 0, 2, 1'b0, -1, a);   // LINK_EN bit0 only -> disable
        issue(2, 1, 2, 0, 1, 1'b1, -1, a);   // link out of range
        issue(0, 1, 1, 0, 5, 1'b1, -1, a);   // data > CHANNELS
        issue(1, 0, 0, 0, 5, 1'b1, -1, a);   // FILL data > CHANNELS
        issue(0, 3, 0, 0, 0, 1'b0, -1, a);   // recovers after errors
        drain();

        issue(3, 0, 0, 0, 0, 1'b0, -1, a);   // CLEAR
        issue(0, 3, 7, 0, 1, 1'b0, -1, a2);  // held valid behind CLEAR
        chk("clear_b2b_accept_cycle", a2, a + 42);
        drain();

        issue(3, 0, 0, 0, 0, 1'b0, 10, a);   // CLEAR aborted by reset
        while (cyc < a + 9) @(negedge clk_noc);
        rst_noc = 1'b0;
        @(negedge clk_noc);
        chk_idle("abort");
        chk("abort_queue_empty", exp_q.size(), 0);
        @(negedge clk_noc);
        rst_noc = 1'b1;
        repeat (3) @(negedge clk_noc);
        chk_idle("post_abort");
        issue(0, 2, 3, 0, 4, 1'b0, -1, a);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
